adder_tree_acc: RTL and testbench
=================================

Name: adder_tree_acc

Overview:
- Pipelined signed adder tree that sums NUM_INPUTS lanes each valid cycle.
- Accumulates a runtime-programmable number of consecutive valid tree sums.
- Scales the accumulated sum by 2^-SHIFT, with convergent or floor rounding.
- Saturates the scaled result to OUTPUT_WIDTH.
- Successor to adder_tree for decimating/integrating DSBPM data paths (e.g. sum of ADC lanes over N turns).

Parameters:
NUM_INPUTS, 10, number of signed input lanes (>=1)
INPUT_WIDTH, 16, bits per lane
OUTPUT_WIDTH, 16, bits of data_out
ACC_LEN_WIDTH, 4, width of acc_len; max block length 2^ACC_LEN_WIDTH-1
SHIFT, 8, LSBs dropped from accumulator before saturation (0..ACC_W-1)
ROUND_CONVERGENT, 1, 1 = round half-to-even on dropped bits; 0 = floor (truncate)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
clear  in  1  synchronous flush of tree pipeline and partial accumulation
acc_len  in  ACC_LEN_WIDTH  tree sums per output block; 0 treated as 1
valid_in  in  1  data_in qualifier
data_in  in  NUM_INPUTS*INPUT_WIDTH  packed signed lanes, lane i at [i*INPUT_WIDTH +: INPUT_WIDTH]
valid_out  out  1  one-cycle strobe per completed block
data_out  out  OUTPUT_WIDTH  signed rounded/saturated block sum
sat_out  out  1  high with valid_out when data_out was clamped

Behaviour:
- Widths: DEPTH=$clog2(NUM_INPUTS), TREE_W=INPUT_WIDTH+DEPTH, ACC_W=TREE_W+ACC_LEN_WIDTH. All arithmetic is signed and full-precision; no internal overflow is possible.
- Tree stage:
  - DEPTH registered pairwise levels (DEPTH=0 means pass-through).
  - An odd element at any level is sign-extended and carried forward.
  - A valid bit travels with the data. No backpressure: every valid_in is accepted.
- Accumulator stage (1 register):
  - acc_len is latched on the first valid tree sum of a block; later changes to acc_len take effect at the next block.
  - Count 1 loads acc with the sum; later counts add the sum to acc.
  - On the count equal to the latched length, the completed sum is passed to the output stage and the count resets.
- Output stage (1 register):
  - r = acc arithmetically shifted right by SHIFT, computed in ACC_W+1 bits.
  - If ROUND_CONVERGENT and SHIFT>0, add the round bit:
    - dropped bits exactly 100..0: add r[0] (half-to-even);
    - otherwise: add the MSB of the dropped bits.
  - Clamp r to [-2^(OUTPUT_WIDTH-1), 2^(OUTPUT_WIDTH-1)-1]. sat_out=1 if clamped.
  - Sign-extend r if OUTPUT_WIDTH exceeds its width.
- Latency: valid_out rises exactly DEPTH+2 cycles after the valid_in edge that completes a block (6 cycles at defaults).
- Gaps in valid_in are allowed anywhere. They stall counting only, not the pipeline. Throughput is one sample per cycle.
- clear:
  - Zeroes all tree valid bits, the accumulator and the count; samples already in the tree are discarded.
  - valid_in in the same cycle as clear is dropped.
  - The output register is unaffected, so a result already in the output stage still emits.
- Reset (async, any time):
  - valid_out=0, data_out=0, sat_out=0, count=0, acc=0, all tree valids=0.
  - The first block after deassertion starts fresh.
- data_out/sat_out hold their last values while valid_out=0.

Test Plan:
- acc_len=2; all lanes 128 on 2 consecutive valids -> data_out=10 (2560/256), sat_out=0, valid_out exactly 6 cycles after the 2nd valid, single-cycle strobe.
- Convergent rounding, acc_len=1, lane0 only:
  - lane0=384 -> 2; lane0=640 -> 2; lane0=-384 -> -2.
  - ROUND_CONVERGENT=0, same inputs -> 1, 2, -2.
- Saturation, SHIFT=4, acc_len=15, 15 valids:
  - all lanes 32767 -> 32767, sat_out=1.
  - all lanes -32768 -> -32768, sat_out=1.
- Gappy stream: acc_len=3, valid_in pattern 1,0,0,1,0,1 with lane sums 100/200/300 scaled ×256 -> exactly one output of 600, 6 cycles after the last valid.
- clear after 2 of 3 valids, then 3 fresh valids of lane-sum 256 -> one output of 3, none for the partial block; valid_in coincident with clear is ignored.
- Block length control and reset:
  - acc_len=0 -> one output per valid.
  - acc_len changed 2->4 mid-block -> current block uses 2, next uses 4.
  - rst asserted mid-block, asynchronously between edges -> outputs 0 immediately; no stale output after release.

Source files
------------

// File: rtl/adder_tree_acc.sv
// adder_tree_acc: pipelined signed adder tree over NUM_INPUTS lanes, followed
// by a block accumulator (runtime length), a 2^-SHIFT scaler with optional
// convergent rounding, and a saturating output register.
//
// Pipeline: input register -> DEPTH tree levels -> accumulator -> output.
// A sample that completes a block shows up on valid_out DEPTH+2 cycles after
// the clock edge that captured it.

module adder_tree_acc #(
   parameter int NUM_INPUTS       = 10,
   parameter int INPUT_WIDTH      = 16,
   parameter int OUTPUT_WIDTH     = 16,
   parameter int ACC_LEN_WIDTH    = 4,
   parameter int SHIFT            = 8,
   parameter int ROUND_CONVERGENT = 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                clear,
   input  logic [ACC_LEN_WIDTH-1:0]            acc_len,
   input  logic                                valid_in,
   input  logic [NUM_INPUTS*INPUT_WIDTH-1:0]   data_in,
   output logic                                valid_out,
   output logic [OUTPUT_WIDTH-1:0]             data_out,
   output logic                                sat_out
);

   localparam int DEPTH  = $clog2(NUM_INPUTS);
   localparam int TREE_W = INPUT_WIDTH + DEPTH;
   localparam int ACC_W  = TREE_W + ACC_LEN_WIDTH;
   localparam int RW     = ACC_W + 1;

   // Number of live nodes at tree level l (level 0 = the input lanes).
   function automatic int lvl_cnt(input int l);
      return (NUM_INPUTS + (1 << l) - 1) >> l;
   endfunction

   // ------------------------------------------------------------------
   // Input register: lanes sign-extended to the full tree width.
   // ------------------------------------------------------------------
   logic signed [INPUT_WIDTH-1:0] w_lane [NUM_INPUTS];
   logic signed [TREE_W-1:0]      r_in   [NUM_INPUTS];
   logic                          r_in_vld;

   for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
      assign w_lane[i] = data_in[i*INPUT_WIDTH +: INPUT_WIDTH];
   end

   // Capture lane data every cycle; qualification travels in r_in_vld.
   // NOTE: datapath registers carry no reset; only the valid bits need one.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
         r_in[i] <= TREE_W'(w_lane[i]);
      end
   end

   // Input valid: a sample coincident with clear is dropped.
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_in_vld <= 1'b0;
      else     r_in_vld <= valid_in & ~clear;
   end

   // ------------------------------------------------------------------
   // Tree levels. An odd trailing node is paired with a zero, which is
   // the same as carrying it forward sign-extended.
   // ------------------------------------------------------------------
   for (genvar l = 1; l <= DEPTH; l++) begin : g_lvl
      localparam int PCNT = lvl_cnt(l - 1);
      localparam int CNT  = lvl_cnt(l);

      logic signed [TREE_W-1:0] w_src [2*CNT];
      logic signed [TREE_W-1:0] r_sum [CNT];
      logic                     w_src_vld;
      logic                     r_vld;

      for (genvar k = 0; k < 2*CNT; k++) begin : g_src
         if (k >= PCNT) begin : g_pad
            assign w_src[k] = '0;
         end else if (l == 1) begin : g_first
            assign w_src[k] = r_in[k];
         end else begin : g_prev
            assign w_src[k] = g_lvl[l-1].r_sum[k];
         end
      end

      if (l == 1) begin : g_vfirst
         assign w_src_vld = r_in_vld;
      end else begin : g_vprev
         assign w_src_vld = g_lvl[l-1].r_vld;
      end

      // Pairwise add of the previous level.
      always_ff @(posedge clk) begin
         for (int j = 0; j < CNT; j++) begin
            r_sum[j] <= w_src[2*j] + w_src[2*j+1];
         end
      end

      // Valid bit riding alongside this level; clear flushes it.
      always_ff @(posedge clk or posedge rst) begin
         if (rst)        r_vld <= 1'b0;
         else if (clear) r_vld <= 1'b0;
         else            r_vld <= w_src_vld;
      end
   end

   logic signed [TREE_W-1:0] w_tree_sum;
   logic                     w_tree_vld;

   if (DEPTH == 0) begin : g_tree_bypass
      assign w_tree_sum = r_in[0];
      assign w_tree_vld = r_in_vld;
   end else begin : g_tree_out
      assign w_tree_sum = g_lvl[DEPTH].r_sum[0];
      assign w_tree_vld = g_lvl[DEPTH].r_vld;
   end

   // ------------------------------------------------------------------
   // Accumulator: block length latched on the first sum of each block.
   // ------------------------------------------------------------------
   logic signed [ACC_W-1:0]   r_acc;
   logic [ACC_LEN_WIDTH-1:0]  r_cnt;
   logic [ACC_LEN_WIDTH-1:0]  r_len;
   logic                      r_acc_done;

   logic signed [ACC_W-1:0]   w_sum_ext;
   logic                      w_first;
   logic                      w_last;
   logic [ACC_LEN_WIDTH-1:0]  w_len_eff;
   logic [ACC_LEN_WIDTH-1:0]  w_cnt_inc;

   // Block bookkeeping: effective length and end-of-block detect.
   // NOTE: every always_comb output gets a default first, so no latches.
   always_comb begin
      w_sum_ext = ACC_W'(w_tree_sum);
      w_first   = (r_cnt == '0);
      w_len_eff = r_len;
      if (w_first) begin
         w_len_eff = (acc_len == '0) ? ACC_LEN_WIDTH'(1) : acc_len;
      end
      w_cnt_inc = r_cnt + ACC_LEN_WIDTH'(1);
      w_last    = (w_cnt_inc == w_len_eff);
   end

   // Accumulate valid tree sums; flag the cycle that holds a finished block.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc      <= '0;
         r_cnt      <= '0;
         r_len      <= '0;
         r_acc_done <= 1'b0;
      end else if (clear) begin
         r_acc      <= '0;
         r_cnt      <= '0;
         r_acc_done <= 1'b0;
      end else begin
         r_acc_done <= w_tree_vld & w_last;
         if (w_tree_vld) begin
            r_acc <= w_first ? w_sum_ext : r_acc + w_sum_ext;
            r_cnt <= w_last ? '0 : w_cnt_inc;
            if (w_first) r_len <= w_len_eff;
         end
      end
   end

   // ------------------------------------------------------------------
   // Scale, round, saturate.
   // ------------------------------------------------------------------
   logic signed [RW-1:0]           w_acc_x;
   logic signed [RW-1:0]           w_shr;
   logic signed [RW-1:0]           w_rnd;
   logic signed [OUTPUT_WIDTH-1:0] w_out;
   logic                           w_sat;

   assign w_acc_x = RW'(r_acc);
   assign w_shr   = w_acc_x >>> SHIFT;

   if (ROUND_CONVERGENT != 0 && SHIFT > 0) begin : g_round
      localparam logic [SHIFT-1:0] HALF = ~({SHIFT{1'b1}} >> 1);
      logic [SHIFT-1:0] w_drop;
      logic             w_rbit;
      assign w_drop = r_acc[SHIFT-1:0];
      // Exact half rounds to even; otherwise round to nearest.
      assign w_rbit = (w_drop == HALF) ? w_shr[0] : w_drop[SHIFT-1];
      assign w_rnd  = w_shr + {{(RW-1){1'b0}}, w_rbit};
   end else begin : g_floor
      assign w_rnd = w_shr;
   end

   if (OUTPUT_WIDTH < RW) begin : g_clamp
      localparam logic signed [RW-1:0] ONE  = 1;
      localparam logic signed [RW-1:0] MINV = -(ONE <<< (OUTPUT_WIDTH - 1));
      localparam logic signed [RW-1:0] MAXV = ~MINV;
      // Clamp to the signed output range and flag it.
      always_comb begin
         w_out = w_rnd[OUTPUT_WIDTH-1:0];
         w_sat = 1'b0;
         if (w_rnd > MAXV) begin
            w_out = MAXV[OUTPUT_WIDTH-1:0];
            w_sat = 1'b1;
         end else if (w_rnd < MINV) begin
            w_out = MINV[OUTPUT_WIDTH-1:0];
            w_sat = 1'b1;
         end
      end
   end else begin : g_wide
      assign w_out = OUTPUT_WIDTH'(w_rnd);
      assign w_sat = 1'b0;
   end

   // ------------------------------------------------------------------
   // Output register: data and sat hold between strobes.
   // ------------------------------------------------------------------
   logic                    r_valid_out;
   logic [OUTPUT_WIDTH-1:0] r_data_out;
   logic                    r_sat_out;

   // Register the finished block; clear deliberately does not touch this.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid_out <= 1'b0;
         r_data_out  <= '0;
         r_sat_out   <= 1'b0;
      end else begin
         r_valid_out <= r_acc_done;
         if (r_acc_done) begin
            r_data_out <= w_out;
            r_sat_out  <= w_sat;
         end
      end
   end

   assign valid_out = r_valid_out;
   assign data_out  = r_data_out;
   assign sat_out   = r_sat_out;

endmodule

// File: tb/tb_adder_tree_acc.sv
// Directed bench for adder_tree_acc. Three instances share the stimulus:
// convergent/SHIFT=8, floor/SHIFT=8 and convergent/SHIFT=4 (saturation).
// Every clock edge is advanced through tick(), which logs output strobes
// per instance together with the edge number they appeared on.

module tb_adder_tree_acc;

   localparam int NI  = 10;
   localparam int IW  = 16;
   localparam int OW  = 16;
   localparam int ALW = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              clear;
   logic              valid_in;
   logic [ALW-1:0]    acc_len;
   logic [NI*IW-1:0]  data_in;

   logic              vo   [3];
   logic [OW-1:0]     dout [3];
   logic              so   [3];

   always #5 clk = ~clk;

   adder_tree_acc #(.NUM_INPUTS(NI), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW),
                    .ACC_LEN_WIDTH(ALW), .SHIFT(8), .ROUND_CONVERGENT(1)) u_conv (
      .clk(clk), .rst(rst), .clear(clear), .acc_len(acc_len), .valid_in(valid_in),
      .data_in(data_in), .valid_out(vo[0]), .data_out(dout[0]), .sat_out(so[0]));

   adder_tree_acc #(.NUM_INPUTS(NI), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW),
                    .ACC_LEN_WIDTH(ALW), .SHIFT(8), .ROUND_CONVERGENT(0)) u_floor (
      .clk(clk), .rst(rst), .clear(clear), .acc_len(acc_len), .valid_in(valid_in),
      .data_in(data_in), .valid_out(vo[1]), .data_out(dout[1]), .sat_out(so[1]));

   adder_tree_acc #(.NUM_INPUTS(NI), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW),
                    .ACC_LEN_WIDTH(ALW), .SHIFT(4), .ROUND_CONVERGENT(1)) u_sat (
      .clk(clk), .rst(rst), .clear(clear), .acc_len(acc_len), .valid_in(valid_in),
      .data_in(data_in), .valid_out(vo[2]), .data_out(dout[2]), .sat_out(so[2]));

   typedef struct {
      int   cyc;
      int   data;
      logic sat;
   } ev_t;

   ev_t q0[$];
   ev_t q1[$];
   ev_t q2[$];
   int  cyc;
   int  n_vec;
   int  n_bad;

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (vo[0]) q0.push_back('{cyc: cyc, data: int'($signed(dout[0])), sat: so[0]});
      if (vo[1]) q1.push_back('{cyc: cyc, data: int'($signed(dout[1])), sat: so[1]});
      if (vo[2]) q2.push_back('{cyc: cyc, data: int'($signed(dout[2])), sat: so[2]});
   endtask

   task automatic drive(input logic v, input logic [NI*IW-1:0] d);
      valid_in = v;
      data_in  = d;
      tick();
   endtask

   task automatic idle(input int n);
      valid_in = 1'b0;
      data_in  = '1;
      repeat (n) tick();
   endtask

   task automatic clrq();
      q0.delete();
      q1.delete();
      q2.delete();
   endtask

   function automatic logic [NI*IW-1:0] lanes(input int n, input int v);
      logic [NI*IW-1:0] d;
      d = '0;
      for (int i = 0; i < n; i++) d[i*IW +: IW] = IW'(v);
      return d;
   endfunction

   function automatic int qsize(input int qi);
      if (qi == 0) return q0.size();
      if (qi == 1) return q1.size();
      return q2.size();
   endfunction

   task automatic check_ev(input string tag, input int qi, input int idx,
                           input int exp_cyc, input int exp_data, input logic exp_sat);
      ev_t e;
      int  n;
      n = qsize(qi);
      n_vec++;
      assert (idx < n) else begin
         n_bad++;
         $error("FAIL %s: output #%0d observed absent expected data %0d", tag, idx, exp_data);
      end
      if (idx < n) begin
         if (qi == 0)      e = q0[idx];
         else if (qi == 1) e = q1[idx];
         else              e = q2[idx];
         check({tag, ".cyc"},  e.cyc,  exp_cyc);
         check({tag, ".data"}, e.data, exp_data);
         check({tag, ".sat"},  e.sat,  exp_sat);
      end
   endtask

   initial begin
      int c;
      int c1;
      cyc      = 0;
      n_vec    = 0;
      n_bad    = 0;
      rst      = 1'b1;
      clear    = 1'b0;
      valid_in = 1'b0;
      acc_len  = 4'd2;
      data_in  = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst.valid_out", vo[0], 1'b0);
      check("rst.data_out", $signed(dout[0]), 0);
      check("rst.sat_out", so[0], 1'b0);
      rst = 1'b0;
      idle(2);

      // Two valids, all lanes 128, acc_len=2 -> 2560/256 = 10
      clrq();
      drive(1'b1, lanes(10, 128));
      drive(1'b1, lanes(10, 128));
      c = cyc;
      idle(12);
      check("basic.count", qsize(0), 1);
      check_ev("basic", 0, 0, c + 6, 10, 1'b0);
      check("basic.hold_valid", vo[0], 1'b0);
      check("basic.hold_data", $signed(dout[0]), 10);

      // Rounding, acc_len=1, lane0 only: 384, 640, -384
      acc_len = 4'd1;
      clrq();
      drive(1'b1, lanes(1, 384));
      drive(1'b1, lanes(1, 640));
      drive(1'b1, lanes(1, -384));
      c = cyc;
      idle(10);
      check("round.count", qsize(0), 3);
      check_ev("conv384", 0, 0, c + 4, 2, 1'b0);
      check_ev("conv640", 0, 1, c + 5, 2, 1'b0);
      check_ev("convm384", 0, 2, c + 6, -2, 1'b0);
      check("floor.count", qsize(1), 3);
      check_ev("floor384", 1, 0, c + 4, 1, 1'b0);
      check_ev("floor640", 1, 1, c + 5, 2, 1'b0);
      check_ev("floorm384", 1, 2, c + 6, -2, 1'b0);

      // Saturation, acc_len=15, all lanes full-scale positive
      acc_len = 4'd15;
      clrq();
      repeat (15) drive(1'b1, lanes(10, 32767));
      c = cyc;
      idle(10);
      check_ev("satpos", 2, 0, c + 6, 32767, 1'b1);
      check_ev("satpos_sh8", 0, 0, c + 6, 19199, 1'b0);

      // Saturation, all lanes full-scale negative
      clrq();
      repeat (15) drive(1'b1, lanes(10, -32768));
      c = cyc;
      idle(10);
      check_ev("satneg", 2, 0, c + 6, -32768, 1'b1);
      check_ev("satneg_sh8", 0, 0, c + 6, -19200, 1'b0);

      // Gappy stream, acc_len=3, pattern 1,0,0,1,0,1
      acc_len = 4'd3;
      clrq();
      drive(1'b1, lanes(1, 25600));
      drive(1'b0, lanes(10, 1000));
      drive(1'b0, lanes(10, 1000));
      drive(1'b1, lanes(2, 25600));
      drive(1'b0, lanes(10, 1000));
      drive(1'b1, lanes(3, 25600));
      c = cyc;
      idle(10);
      check("gappy.count", qsize(0), 1);
      check_ev("gappy", 0, 0, c + 6, 600, 1'b0);

      // clear with one partial sum in the accumulator, one in the tree,
      // and a valid coincident with clear; then a fresh block of three
      clrq();
      drive(1'b1, lanes(10, 512));
      idle(6);
      drive(1'b1, lanes(10, 512));
      clear = 1'b1;
      drive(1'b1, lanes(10, 512));
      clear = 1'b0;
      drive(1'b1, lanes(1, 256));
      drive(1'b1, lanes(1, 256));
      drive(1'b1, lanes(1, 256));
      c = cyc;
      idle(10);
      check("clear.count", qsize(0), 1);
      check_ev("clear", 0, 0, c + 6, 3, 1'b0);

      // acc_len=0 behaves as 1
      acc_len = 4'd0;
      clrq();
      drive(1'b1, lanes(1, 256));
      drive(1'b1, lanes(1, 512));
      drive(1'b1, lanes(1, 768));
      c = cyc;
      idle(10);
      check("len0.count", qsize(0), 3);
      check_ev("len0_a", 0, 0, c + 4, 1, 1'b0);
      check_ev("len0_b", 0, 1, c + 5, 2, 1'b0);
      check_ev("len0_c", 0, 2, c + 6, 3, 1'b0);

      // acc_len 2 -> 4 mid-block: current block keeps 2, next uses 4
      acc_len = 4'd2;
      clrq();
      drive(1'b1, lanes(1, 256));
      idle(8);
      acc_len = 4'd4;
      drive(1'b1, lanes(1, 512));
      c1 = cyc;
      repeat (4) drive(1'b1, lanes(1, 256));
      c = cyc;
      idle(10);
      check("lenchg.count", qsize(0), 2);
      check_ev("lenchg_a", 0, 0, c1 + 6, 3, 1'b0);
      check_ev("lenchg_b", 0, 1, c + 6, 4, 1'b0);

      // Asynchronous reset mid-block, between clock edges
      acc_len = 4'd2;
      clrq();
      drive(1'b1, lanes(1, 256));
      idle(2);
      #3;
      rst = 1'b1;
      #1;
      check("arst.valid_out", vo[0], 1'b0);
      check("arst.data_out", $signed(dout[0]), 0);
      check("arst.data_out_sh4", $signed(dout[2]), 0);
      @(posedge clk);
      #3;
      rst = 1'b0;
      tick();
      clrq();
      drive(1'b1, lanes(1, 256));
      idle(10);
      check("arst.no_stale", qsize(0), 0);
      drive(1'b1, lanes(1, 512));
      c = cyc;
      idle(10);
      check("arst.count", qsize(0), 1);
      check_ev("arst_fresh", 0, 0, c + 6, 3, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
